// File: rtl/rtc_poller.sv
// rtc_poller: periodically reads sec/min/hour from a DS1307-style RTC through an
// I2C master, validates the BCD result and publishes it; also issues one-shot
// time-set writes on request.
module rtc_poller #(
  parameter int unsigned ClockFrequency = 1000000,
  parameter int unsigned PollPeriodMs   = 500,
  parameter logic [6:0]  RtcAddress     = 7'h68,
  parameter int unsigned MaxBytesToSend = 16,
  parameter int unsigned MaxBytesToRead = 16
) (
  input  logic                                  reset,
  input  logic                                  clock,
  input  logic                                  enable,
  input  logic                                  setTime,
  input  logic [7:0]                            setSecondsBcd,
  input  logic [7:0]                            setMinutesBcd,
  input  logic [7:0]                            setHoursBcd,
  output logic                                  i2cStart,
  output logic [6:0]                            i2cAddress,
  output logic [$clog2(MaxBytesToSend):0]       i2cNrOfBytesToSend,
  output logic [MaxBytesToSend-1:0][7:0]        i2cBytesToSend,
  output logic [$clog2(MaxBytesToRead):0]       i2cNrOfBytesToRead,
  input  logic [MaxBytesToRead-1:0][7:0]        i2cBytesToRead,
  input  logic                                  i2cReady,
  input  logic                                  i2cClockStretchTimeoutReached,
  output logic [6:0]                            secondsBcd,
  output logic [6:0]                            minutesBcd,
  output logic [5:0]                            hoursBcd,
  output logic                                  timeValid,
  output logic                                  error,
  output logic                                  busy
);

  localparam int unsigned SendCntW    = $clog2(MaxBytesToSend) + 1;
  localparam int unsigned ReadCntW    = $clog2(MaxBytesToRead) + 1;
  localparam int unsigned CyclesPerMs = ClockFrequency / 1000;
  localparam int unsigned PollCycles  = CyclesPerMs * PollPeriodMs - 1;
  localparam int unsigned PollCntW    = (PollCycles > 0) ? $clog2(PollCycles + 1) : 1;
  localparam int unsigned WaitLimit   = 2 * CyclesPerMs + 2;
  localparam int unsigned WaitCntW    = $clog2(WaitLimit + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CHECK} state_t;

  state_t                state, state_next;
  logic [PollCntW-1:0]   poll_cnt;
  logic                  poll_due;
  logic [WaitCntW-1:0]   wait_cnt;
  logic                  pending_set;
  logic                  is_write;
  logic [7:0]            set_sec, set_min, set_hr;
  logic                  issue_read_c, issue_write_c, wait_expired_c, check_ok_c;
  logic [6:0]            rd_sec_c, rd_min_c;
  logic [5:0]            rd_hr_c;
  logic                  start_d, busy_d;
  logic                  unused_read_bytes;

  assign i2cAddress        = RtcAddress;
  assign unused_read_bytes = ^i2cBytesToRead;

  // A pending write always wins over a due poll.
  assign issue_write_c  = (state == IDLE) && pending_set;
  assign issue_read_c   = (state == IDLE) && !pending_set && poll_due && enable;
  assign wait_expired_c = (state == WAIT_BUSY) && i2cReady &&
                          (wait_cnt == WaitCntW'(WaitLimit - 1));

  // Received bytes with CH / 12-24h control bits stripped, plus BCD range check.
  assign rd_sec_c   = i2cBytesToRead[0][6:0];
  assign rd_min_c   = i2cBytesToRead[1][6:0];
  assign rd_hr_c    = i2cBytesToRead[2][5:0];
  assign check_ok_c = (rd_sec_c[3:0] <= 4'd9) && (rd_sec_c <= 7'h59) &&
                      (rd_min_c[3:0] <= 4'd9) && (rd_min_c <= 7'h59) &&
                      (rd_hr_c[3:0]  <= 4'd9) && (rd_hr_c  <= 6'h23);

  // Free-running poll timer; expires immediately after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      poll_cnt <= '0;
      poll_due <= 1'b0;
    end else if (poll_cnt == '0) begin
      poll_cnt <= PollCntW'(PollCycles);
      poll_due <= 1'b1;
    end else begin
      poll_cnt <= poll_cnt - PollCntW'(1);
      if (issue_read_c) poll_due <= 1'b0;
    end
  end

  // Capture time-set requests; a new pulse overrides both clear and old values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_set <= 1'b0;
      set_sec     <= '0;
      set_min     <= '0;
      set_hr      <= '0;
    end else if (setTime) begin
      pending_set <= 1'b1;
      set_sec     <= setSecondsBcd;
      set_min     <= setMinutesBcd;
      set_hr      <= setHoursBcd;
    end else if (issue_write_c) begin
      pending_set <= 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (pending_set || (poll_due && enable)) state_next = ISSUE;
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (!i2cReady)          state_next = WAIT_DONE;
                 else if (wait_expired_c) state_next = IDLE;
      WAIT_DONE: if (i2cReady) begin
                   if (i2cClockStretchTimeoutReached || is_write) state_next = IDLE;
                   else                                           state_next = CHECK;
                 end
      CHECK:     state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state, registered below.
  always_comb begin
    start_d = 1'b0;
    busy_d  = 1'b0;
    if (state_next == ISSUE) start_d = 1'b1;
    if (state_next != IDLE)  busy_d  = 1'b1;
  end

  // Registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i2cStart <= 1'b0;
      busy     <= 1'b0;
    end else begin
      i2cStart <= start_d;
      busy     <= busy_d;
    end
  end

  // Transaction descriptor, loaded on leaving Idle and held until the next load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i2cNrOfBytesToSend <= '0;
      i2cNrOfBytesToRead <= '0;
      i2cBytesToSend     <= '0;
      is_write           <= 1'b0;
    end else if (issue_write_c) begin
      i2cNrOfBytesToSend <= SendCntW'(4);
      i2cNrOfBytesToRead <= '0;
      i2cBytesToSend     <= '0;
      i2cBytesToSend[1]  <= set_sec & 8'h7F;
      i2cBytesToSend[2]  <= set_min;
      i2cBytesToSend[3]  <= set_hr & 8'h3F;
      is_write           <= 1'b1;
    end else if (issue_read_c) begin
      i2cNrOfBytesToSend <= SendCntW'(1);
      i2cNrOfBytesToRead <= ReadCntW'(3);
      i2cBytesToSend     <= '0;
      is_write           <= 1'b0;
    end
  end

  // Bounded wait for the master to acknowledge the start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   wait_cnt <= '0;
    else if (state == ISSUE)     wait_cnt <= '0;
    else if (state == WAIT_BUSY) wait_cnt <= wait_cnt + WaitCntW'(1);
  end

  // Result tracking: error flag and validated time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error      <= 1'b0;
      timeValid  <= 1'b0;
      secondsBcd <= '0;
      minutesBcd <= '0;
      hoursBcd   <= '0;
    end else if (wait_expired_c) begin
      error <= 1'b1;
    end else if (state == WAIT_DONE && i2cReady) begin
      if (i2cClockStretchTimeoutReached) error <= 1'b1;
      else if (is_write)                 error <= 1'b0;
    end else if (state == CHECK) begin
      if (check_ok_c) begin
        secondsBcd <= rd_sec_c;
        minutesBcd <= rd_min_c;
        hoursBcd   <= rd_hr_c;
        timeValid  <= 1'b1;
        error      <= 1'b0;
      end else begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rtc_poller.sv
// tb_rtc_poller: scoreboard bench with an I2C master model and a time reference model.
module tb_rtc_poller;

  localparam int PERIOD = 2000;
  localparam int TMO    = 2 * 1000 + 2;
  localparam int M_OK = 0, M_STRETCH = 1, M_NEVER = 2;

  typedef struct { int mode; logic [7:0] b0, b1, b2; int drop; int len; } resp_t;
  typedef struct { bit wr; logic [7:0] b1, b2, b3; int rd_gap; int fall_gap; } start_t;
  typedef struct { bit err; bit valid; logic [6:0] s, m; logic [5:0] h; int fall_dly; } res_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic setTime = 1'b0;
  logic [7:0] setSecondsBcd = '0, setMinutesBcd = '0, setHoursBcd = '0;
  logic i2cStart;
  logic [6:0] i2cAddress;
  logic [4:0] i2cNrOfBytesToSend, i2cNrOfBytesToRead;
  logic [15:0][7:0] i2cBytesToSend;
  logic [15:0][7:0] i2cBytesToRead = '0;
  logic i2cReady = 1'b1;
  logic i2cClockStretchTimeoutReached = 1'b0;
  logic [6:0] secondsBcd, minutesBcd;
  logic [5:0] hoursBcd;
  logic timeValid, error, busy;

  rtc_poller #(.ClockFrequency(1000000), .PollPeriodMs(2), .RtcAddress(7'h68),
               .MaxBytesToSend(16), .MaxBytesToRead(16)) dut (
    .reset(reset), .clock(clock), .enable(enable), .setTime(setTime),
    .setSecondsBcd(setSecondsBcd), .setMinutesBcd(setMinutesBcd), .setHoursBcd(setHoursBcd),
    .i2cStart(i2cStart), .i2cAddress(i2cAddress),
    .i2cNrOfBytesToSend(i2cNrOfBytesToSend), .i2cBytesToSend(i2cBytesToSend),
    .i2cNrOfBytesToRead(i2cNrOfBytesToRead), .i2cBytesToRead(i2cBytesToRead),
    .i2cReady(i2cReady), .i2cClockStretchTimeoutReached(i2cClockStretchTimeoutReached),
    .secondsBcd(secondsBcd), .minutesBcd(minutesBcd), .hoursBcd(hoursBcd),
    .timeValid(timeValid), .error(error), .busy(busy));

  always #5 clock = ~clock;

  int tests = 0, fails = 0;
  int cyc = 0, last_read_cyc = 0, last_fall_cyc = 0, last_start_cyc = 0;
  int start_cnt = 0, done_cnt = 0;
  resp_t  resp_q[$];
  start_t start_q[$];
  res_t   res_q[$];

  // Reference model of the published time.
  logic [6:0] m_s = '0, m_m = '0;
  logic [5:0] m_h = '0;
  bit m_valid = 1'b0, m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit bcd_ok(input int v, input int lim);
    return (v % 16 < 10) && ((v / 16) * 10 + v % 16 < lim);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic plan_read(input logic [7:0] b0, b1, b2, input int mode, input int gap);
    resp_t r; start_t s; res_t e;
    int sv, mv, hv;
    r.mode = mode; r.b0 = b0; r.b1 = b1; r.b2 = b2;
    r.drop = $urandom_range(3, 1); r.len = $urandom_range(60, 5);
    resp_q.push_back(r);
    s.wr = 1'b0; s.b1 = '0; s.b2 = '0; s.b3 = '0; s.rd_gap = gap; s.fall_gap = 0;
    start_q.push_back(s);
    sv = int'(b0) % 128; mv = int'(b1) % 128; hv = int'(b2) % 64;
    if (mode == M_OK && bcd_ok(sv, 60) && bcd_ok(mv, 60) && bcd_ok(hv, 24)) begin
      m_s = 7'(sv); m_m = 7'(mv); m_h = 6'(hv); m_valid = 1'b1; m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    e.err = m_err; e.valid = m_valid; e.s = m_s; e.m = m_m; e.h = m_h;
    e.fall_dly = (mode == M_NEVER) ? TMO + 1 : 0;
    res_q.push_back(e);
  endtask

  task automatic plan_valid_read(input int mode, input int gap);
    logic [7:0] b0, b1, b2;
    b0 = to_bcd($urandom_range(59, 0)) | 8'($urandom_range(1, 0) << 7);
    b1 = to_bcd($urandom_range(59, 0)) | 8'($urandom_range(1, 0) << 7);
    b2 = to_bcd($urandom_range(23, 0)) | 8'($urandom_range(3, 0) << 6);
    plan_read(b0, b1, b2, mode, gap);
  endtask

  task automatic plan_write(input logic [7:0] s, m, h, input int fall_gap);
    resp_t r; start_t st; res_t e;
    r.mode = M_OK; r.b0 = '0; r.b1 = '0; r.b2 = '0;
    r.drop = $urandom_range(3, 1); r.len = $urandom_range(40, 5);
    resp_q.push_back(r);
    st.wr = 1'b1; st.b1 = s & 8'h7F; st.b2 = m; st.b3 = h & 8'h3F;
    st.rd_gap = 0; st.fall_gap = fall_gap;
    start_q.push_back(st);
    m_err = 1'b0;
    e.err = m_err; e.valid = m_valid; e.s = m_s; e.m = m_m; e.h = m_h; e.fall_dly = 0;
    res_q.push_back(e);
  endtask

  task automatic pulse_set(input logic [7:0] s, m, h);
    @(negedge clock);
    setSecondsBcd = s; setMinutesBcd = m; setHoursBcd = h; setTime = 1'b1;
    @(negedge clock);
    setTime = 1'b0;
    setSecondsBcd = 8'($urandom); setMinutesBcd = 8'($urandom); setHoursBcd = 8'($urandom);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 5000) begin @(negedge clock); n++; end
    chk("busy_seen", busy, 1);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 8000) begin @(negedge clock); n++; end
    chk("done_count", done_cnt, target);
  endtask

  // Cycle counter on active edges.
  initial forever begin @(posedge clock); cyc++; end

  // I2C master model: acknowledges each start and returns queued data.
  initial begin
    resp_t r;
    forever begin
      @(negedge clock);
      if (!reset && i2cStart) begin
        i2cClockStretchTimeoutReached = 1'b0;
        if (resp_q.size() > 0) r = resp_q.pop_front();
        else begin
          r.mode = M_OK; r.b0 = '0; r.b1 = '0; r.b2 = '0; r.drop = 1; r.len = 5;
        end
        if (r.mode != M_NEVER) begin
          repeat (r.drop) @(negedge clock);
          i2cReady = 1'b0;
          repeat (r.len) @(negedge clock);
          i2cBytesToRead[0] = r.b0;
          i2cBytesToRead[1] = r.b1;
          i2cBytesToRead[2] = r.b2;
          i2cClockStretchTimeoutReached = (r.mode == M_STRETCH);
          i2cReady = 1'b1;
        end
      end
    end
  end

  // Monitor: checks every start against the queue and every completion against the model.
  initial begin
    start_t s; res_t e;
    bit busy_prev = 1'b0, start_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        busy_prev = 1'b0; start_prev = 1'b0;
      end else begin
        if (start_prev) chk("start_pulse_width", i2cStart, 0);
        if (i2cStart) begin
          start_cnt++;
          if (start_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_start: got a start at cycle %0d, expected none", cyc);
          end else begin
            s = start_q.pop_front();
            chk("address", i2cAddress, 7'h68);
            chk("send_count", i2cNrOfBytesToSend, s.wr ? 4 : 1);
            chk("send_byte0", i2cBytesToSend[0], 0);
            chk("read_count", i2cNrOfBytesToRead, s.wr ? 0 : 3);
            if (s.wr) begin
              chk("send_byte1", i2cBytesToSend[1], s.b1);
              chk("send_byte2", i2cBytesToSend[2], s.b2);
              chk("send_byte3", i2cBytesToSend[3], s.b3);
            end
            if (s.rd_gap > 0)   chk("poll_gap", cyc - last_read_cyc, s.rd_gap);
            if (s.fall_gap > 0) chk("write_after_read", cyc - last_fall_cyc, s.fall_gap);
            if (!s.wr) last_read_cyc = cyc;
            last_start_cyc = cyc;
          end
        end
        if (busy_prev && !busy) begin
          last_fall_cyc = cyc;
          if (res_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_completion: got busy fall at cycle %0d, expected none", cyc);
          end else begin
            e = res_q.pop_front();
            chk("error", error, e.err);
            chk("time_valid", timeValid, e.valid);
            chk("seconds", secondsBcd, e.s);
            chk("minutes", minutesBcd, e.m);
            chk("hours", hoursBcd, e.h);
            if (e.fall_dly > 0) chk("busy_timeout_cycles", cyc - last_start_cyc, e.fall_dly);
          end
          done_cnt++;
        end
        busy_prev = busy;
        start_prev = i2cStart;
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int target, saved;
    logic [7:0] ws, wm, wh;
    repeat (3) @(negedge clock);
    chk("rst_start", i2cStart, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_valid", timeValid, 0);
    chk("rst_time", {secondsBcd, minutesBcd, hoursBcd}, 0);
    chk("rst_counts", {i2cNrOfBytesToSend, i2cNrOfBytesToRead}, 0);
    chk("rst_bytes_zero", (i2cBytesToSend == '0), 1);

    // First poll is immediate: start two cycles after release.
    plan_read(8'h85, 8'h34, 8'h12, M_OK, 2);
    @(negedge clock);
    reset = 1'b0;
    last_read_cyc = cyc;
    wait_done(1);
    plan_read(8'h5A, 8'h00, 8'h00, M_OK, PERIOD);
    wait_done(2);

    // Time-set during a busy read is issued right after it.
    plan_valid_read(M_OK, PERIOD);
    plan_write(8'h30, 8'h45, 8'h23, 1);
    wait_busy();
    repeat (2) @(negedge clock);
    pulse_set(8'h30, 8'h45, 8'h23);
    wait_done(4);

    // Clock-stretch failure then recovery.
    plan_valid_read(M_STRETCH, PERIOD);
    plan_valid_read(M_OK, PERIOD);
    wait_done(6);

    // Master never acknowledges; the due poll is served on return, only once.
    plan_valid_read(M_NEVER, PERIOD);
    plan_valid_read(M_OK, TMO + 2);
    plan_valid_read(M_OK, 2 * PERIOD - (TMO + 2));
    wait_done(9);

    // Random reads, some invalid, some with a time-set request.
    target = 9;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(9, 0) < 7) plan_valid_read(M_OK, PERIOD);
      else plan_read(8'($urandom), 8'($urandom), 8'($urandom), M_OK, PERIOD);
      target++;
      if ($urandom_range(9, 0) < 3) begin
        ws = 8'($urandom); wm = 8'($urandom); wh = 8'($urandom);
        plan_write(ws, wm, wh, 1);
        target++;
        wait_busy();
        repeat (2) @(negedge clock);
        pulse_set(ws, wm, wh);
      end
      wait_done(target);
    end

    // Disabled: no polls, but a time-set still goes out.
    @(negedge clock);
    enable = 1'b0;
    saved = start_cnt;
    repeat (4500) @(negedge clock);
    chk("no_start_when_disabled", start_cnt, saved);
    ws = 8'($urandom); wm = 8'($urandom); wh = 8'($urandom);
    plan_write(ws, wm, wh, 0);
    target++;
    pulse_set(ws, wm, wh);
    wait_done(target);
    chk("write_only_when_disabled", start_cnt, saved + 1);

    // Re-enable (poll already due), then reset in the middle of that read.
    plan_valid_read(M_OK, 0);
    @(negedge clock);
    enable = 1'b1;
    wait_busy();
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_start", i2cStart, 0);
    chk("async_rst_error", error, 0);
    chk("async_rst_valid", timeValid, 0);
    chk("async_rst_time", {secondsBcd, minutesBcd, hoursBcd}, 0);
    chk("async_rst_counts", {i2cNrOfBytesToSend, i2cNrOfBytesToRead}, 0);
    chk("async_rst_bytes_zero", (i2cBytesToSend == '0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test by cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rtc_poller.md
# rtc_poller

Transaction sequencer that sits directly upstream of the I2C master in the clock design. It periodically reads seconds, minutes and hours from a DS1307-compatible RTC at a fixed 7-bit address, and drives the master's start/address/byte-count/byte-array inputs. It checks the result, masks the control bits, and publishes validated BCD time to the display path. It also performs a one-shot time-set write on request.

## Interface

Parameters:
- ClockFrequency, 1000000: system clock in Hz; must match the I2C master.
- PollPeriodMs, 500: interval between read transactions, in ms.
- RtcAddress, 7'h68: 7-bit RTC address.
- MaxBytesToSend, 16: must match the master; must be ≥ 4.
- MaxBytesToRead, 16: must match the master; must be ≥ 3.

Ports:
- reset  in  1  asynchronous, active-high.
- clock  in  1  system clock.
- enable  in  1  1 = periodic polling allowed.
- setTime  in  1  one-cycle pulse requesting a time write.
- setSecondsBcd / setMinutesBcd / setHoursBcd  in  8 each  values sampled when setTime=1.
- i2cStart  out  1  one-cycle start pulse to the master.
- i2cAddress  out  7  constant RtcAddress.
- i2cNrOfBytesToSend  out  $clog2(MaxBytesToSend)+1  byte count for the write phase.
- i2cBytesToSend  out  MaxBytesToSend x 8  element [0] is sent first.
- i2cNrOfBytesToRead  out  $clog2(MaxBytesToRead)+1  byte count for the read phase.
- i2cBytesToRead  in  MaxBytesToRead x 8  element [0] is received first.
- i2cReady  in  1  master idle.
- i2cClockStretchTimeoutReached  in  1  master failure flag.
- secondsBcd / minutesBcd  out  7 each  latched time.
- hoursBcd  out  6  latched time, 24 h.
- timeValid  out  1  latched time is valid.
- error  out  1  sticky; set on the last transaction failing, cleared by the next successful one.
- busy  out  1  a transaction is in flight.

## Operation

- Reset values:
  - all time outputs 0; timeValid 0; error 0; busy 0; i2cStart 0.
  - byte counts 0; i2cBytesToSend all 0.
  - pending-set flag 0; poll counter preloaded to expire, so the first poll is immediate.
- Poll counter:
  - Reload value PollCycles = (ClockFrequency/1000)*PollPeriodMs - 1.
  - Counts down every cycle in any state.
  - Sets a poll-due flag at 0 and reloads. The flag is cleared when a read is issued.
- A setTime pulse in any state sets the pending-set flag and captures the three set values. A later pulse overwrites the captured values.
- State machine:
  - **Idle**
    - If pending-set is set: load a write transaction, go to Issue. Pending-set has priority over poll-due.
    - Else if poll-due && enable: load a read transaction, go to Issue.
  - **Issue**
    - i2cStart=1 for exactly this cycle; busy=1.
    - Clear the wait counter; go to WaitBusy.
  - **WaitBusy**
    - When i2cReady=0: go to WaitDone.
    - If the wait counter reaches 2*(ClockFrequency/1000)+2 first: error=1, go to Idle.
  - **WaitDone**
    - On i2cReady=1:
      - if i2cClockStretchTimeoutReached=1: error=1, go to Idle, time outputs unchanged;
      - otherwise go to Check (read) or to Idle with error=0 (write).
  - **Check** (read only):
    - s = byte[0] & 7'h7F (clears CH), m = byte[1] & 7'h7F, h = byte[2] & 6'h3F.
    - A nibble > 9, or s > 0x59, m > 0x59, h > 0x23, gives error=1 with outputs unchanged.
    - Otherwise latch s/m/h, timeValid=1, error=0.
    - Go to Idle.
- busy=1 from Issue through the final cycle of WaitDone/Check.
- Transaction loads, held stable from Idle exit until return to Idle:
  - Read: send=1, bytes[0]=8'h00; read=3.
  - Write: send=4, bytes[0..3] = {8'h00, setSecondsBcd & 8'h7F (CH=0 starts the oscillator), setMinutesBcd, setHoursBcd & 8'h3F}; read=0; pending-set cleared.
- enable falling mid-transaction does not abort; the transaction completes normally.
- Asynchronous reset mid-transaction returns to reset values immediately.

## Timing

- i2cStart is a single-cycle pulse. The master latches it internally, so no hold is required.
- Latency from poll-due to i2cStart: 2 cycles (Idle → Issue, registered output).
- Time outputs and timeValid update on the clock edge leaving Check, one cycle after i2cReady returns high.
- Poll interval is measured start-to-start: the counter is free-running and not restarted by transaction length. A poll-due that arrives while busy is served on return to Idle and is not queued twice.

## Test plan

- Reset release, enable=1, master model returns {8'h85, 8'h34, 8'h12}:
  - required: i2cStart pulses with send=1, bytes[0]=0, read=3;
  - then seconds=7'h05, minutes=7'h34, hours=6'h12, timeValid=1, error=0.
- Model returns {8'h5A, 8'h00, 8'h00}:
  - required: error=1;
  - previous time outputs retained.
- setTime pulse with {8'h30, 8'h45, 8'h23} while a read is busy:
  - required: write issued right after the read completes;
  - send=4, bytes = {00, 30, 45, 23}, read=0.
- Model asserts clockStretchTimeoutReached with ready=1:
  - required: error=1, back to Idle, next poll retries, and a success clears error.
- Model never drops ready:
  - required: error=1 exactly 2*(ClockFrequency/1000)+2 cycles after WaitBusy entry.
- ClockFrequency=1000000, PollPeriodMs=2:
  - required: consecutive i2cStart pulses exactly 2000 cycles apart.
  - enable=0 stops new pulses.
